// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor front end: widths, reset PC,
// instruction field positions and the fetch FSM encoding.
package cpu_pkg;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;

    localparam int unsigned OPC_MSB   = 15;
    localparam int unsigned OPC_LSB   = 12;
    localparam int unsigned OPC_W     = OPC_MSB - OPC_LSB + 1;
    localparam int unsigned IMM_MSB   = 7;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned IMM_W     = IMM_MSB - IMM_LSB + 1;

    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned CNT_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] word;
    } fetch_entry_t;

    function automatic logic [OPC_W-1:0] get_opcode(input logic [DATA_W-1:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

    function automatic logic [IMM_W-1:0] get_imm8(input logic [DATA_W-1:0] w);
        return w[IMM_MSB:IMM_LSB];
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, word} fetched instructions; flush wins over push/pop.
module fetch_buffer
    import cpu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push_i,
    input  fetch_entry_t       push_entry_i,
    input  logic               pop_i,
    input  logic               flush_i,
    output logic [CNT_W-1:0]   count_o,
    output fetch_entry_t       head_o
);

    fetch_entry_t       mem_q [BUF_DEPTH];
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               we;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        we       = 1'b0;
        if (flush_i) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            // Guards keep the pointers sane even if a caller misbehaves.
            we = push_i && (count_q != CNT_W'(BUF_DEPTH));
            if (we) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_i && (count_q != '0)) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + CNT_W'(we) - CNT_W'(pop_i && (count_q != '0));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (we) begin
                mem_q[wr_ptr_q] <= push_entry_i;
            end
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to instruction memory, queues
// returned words with their PCs and hands the head to decode; redirect flushes.
module fetch_unit
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                redirect,
    input  logic [ADDR_W-1:0]   redirect_pc,
    output logic                ir_valid,
    input  logic                ir_ready,
    output logic [DATA_W-1:0]   ir,
    output logic [ADDR_W-1:0]   ir_pc,
    output logic [OPC_W-1:0]    opcode,
    output logic [IMM_W-1:0]    imm8
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               mem_req_q, mem_req_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;

    logic               push;
    logic               flush;
    logic               pop;
    logic [CNT_W-1:0]   buf_count;
    logic [CNT_W-1:0]   occ_after_pop;
    fetch_entry_t       push_entry;
    fetch_entry_t       head;

    assign pop           = ir_valid & ir_ready;
    assign occ_after_pop = buf_count - CNT_W'(pop);
    assign push_entry    = '{pc: pc_q, word: mem_rdata};

    fetch_buffer u_buf (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop & ~redirect),
        .flush_i      (flush),
        .count_o      (buf_count),
        .head_o       (head)
    );

    // Next-state, PC and request logic; redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end else if (occ_after_pop < CNT_W'(BUF_DEPTH)) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    flush   = 1'b1;
                    pc_d    = redirect_pc;
                    state_d = mem_ack ? ST_IDLE : ST_DROP;
                end else if (mem_ack) begin
                    push    = 1'b1;
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = (occ_after_pop == '0) ? ST_WAIT : ST_IDLE;
                end
            end
            ST_DROP: begin
                if (redirect) begin
                    flush = 1'b1;
                    pc_d  = redirect_pc;
                end
                if (mem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        mem_req_d  = (state_d != ST_IDLE);
        // A request being discarded keeps its original address until acked.
        mem_addr_d = (state_d == ST_DROP) ? mem_addr_q : pc_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign ir_valid = (buf_count != '0);
    assign ir       = head.word;
    assign ir_pc    = head.pc;
    assign opcode   = get_opcode(head.word);
    assign imm8     = get_imm8(head.word);

endmodule
